seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor and the successor of the 8-bit combinational adder chain.
- Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through a registered carry.
- Trades latency for a short critical path on wide datapaths.
- Sits between producer and consumer stages with valid/ready handshakes on both sides.

---
 rtl/seq_chunk_adder.sv | 114 +++++++++++
 tb/tb_seq_chunk_adder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Adds/subtracts two WIDTH-bit operands CHUNK bits per cycle via a registered carry; SEQ_CHUNK_ADDER_OVF_EN adds ovf.
// Latency is NCH cycles from accept to out_valid, with one op in flight; a stalled result holds in DONE until out_ready.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic [CHUNK:0]   add_res;
  logic             c_ch, last;

  assign base    = 32'(cnt) * CHUNK;
  assign a_ch    = op_a[base +: CHUNK];
  assign b_ch    = op_b[base +: CHUNK];
  assign add_res = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
  assign s_ch    = add_res[CHUNK-1:0];
  assign c_ch    = add_res[CHUNK];
  assign last    = (cnt == CW'(NCH - 1));

  always_comb begin
    acc_nx = acc;
    acc_nx[base +: CHUNK] = s_ch;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is folded into the add: A + ~B + ~borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a  <= a;
          op_b  <= sub ? ~b : b;
          carry <= sub ? ~cin : cin;
          cnt   <= '0;
        end
        RUN: begin
          acc   <= acc_nx;
          carry <= c_ch;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum  <= acc_nx;
            cout <= c_ch;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            // Carry into the MSB recovered from the MSB's own sum bit.
            ovf  <= (a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1]) ^ c_ch;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder; CHUNK=8 by default, CHUNK=WIDTH when SEQ_CHUNK_ADDER_OVF_EN is defined.
module tb_seq_chunk_adder;

  localparam int W   = 32;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  localparam int CH  = 32;
`else
  localparam int CH  = 8;
`endif
  localparam int NCH = W / CH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic         ovf;
`endif

  seq_chunk_adder #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] r_sum;
  logic         r_cout, r_ovf, r_busy_ok;
  int           r_lat;

  task automatic wait_valid();
    r_lat = 0;
    r_busy_ok = 1'b1;
    while (!out_valid && r_lat < 50) begin
      if (in_ready) r_busy_ok = 1'b0;
      @(posedge clk); #1;
      r_lat++;
    end
    if (r_lat >= 50) check("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  // Operands are scrambled right after accept to show they are not resampled.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin, input logic tsub);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) check("accept_timeout", 64'(in_ready), 64'd1);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1; cin = ~tcin; sub = ~tsub;
    wait_valid();
    r_sum  = sum;
    r_cout = cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    r_ovf  = ovf;
`else
    r_ovf  = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit stable;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_cout",      64'(cout),      64'd0);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("add_sum",  64'(r_sum),  64'h0000_0100);
    check("add_cout", 64'(r_cout), 64'd0);
    check("add_lat",  64'(r_lat),  64'(NCH));
    check("add_busy", 64'(r_busy_ok), 64'd1);

    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    check("ripple_sum",  64'(r_sum),  64'h0);
    check("ripple_cout", 64'(r_cout), 64'd1);

    run_op(32'd5, 32'd7, 1'b0, 1'b1);
    check("sub_borrow_sum",  64'(r_sum),  64'hFFFF_FFFE);
    check("sub_borrow_cout", 64'(r_cout), 64'd0);

    run_op(32'd7, 32'd5, 1'b1, 1'b1);
    check("sub_cin_sum",  64'(r_sum),  64'd1);
    check("sub_cin_cout", 64'(r_cout), 64'd1);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("allones_sum",  64'(r_sum),  64'hFFFF_FFFF);
    check("allones_cout", 64'(r_cout), 64'd1);

    // Backpressure: second op offered throughout the stall.
    a = 32'h10; b = 32'h20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h100; b = 32'h200;
    wait_valid();
    stable = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (sum !== 32'h30 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_sum1",   64'(sum),    64'h30);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", 64'(in_ready),  64'd1);
    check("bp_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    check("bp_sum2", 64'(sum), 64'h300);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the second RUN cycle.
    a = 32'hAAAA_0000; b = 32'h5555_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_in_ready",  64'(in_ready),  64'd1);
    check("mrst_sum",       64'(sum),       64'd0);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    stable = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stable = 1'b0;
    end
    check("mrst_no_result", 64'(stable), 64'd1);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    check("mrst_next_sum",  64'(r_sum),  64'h2345_6789);
    check("mrst_next_cout", 64'(r_cout), 64'd0);

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    check("ovf_pos_sum", 64'(r_sum), 64'h8000_0000);
    check("ovf_pos",     64'(r_ovf), 64'd1);
    check("ovf_pos_lat", 64'(r_lat), 64'd1);
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    check("ovf_neg_sum", 64'(r_sum), 64'h7FFF_FFFF);
    check("ovf_neg",     64'(r_ovf), 64'd1);
    run_op(32'd3, 32'd4, 1'b0, 1'b0);
    check("ovf_none_sum", 64'(r_sum), 64'd7);
    check("ovf_none",     64'(r_ovf), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
